// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM arbiter: FSM states, client slot numbers, bus widths.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int CLI_LOAD   = 0;
  localparam int CLI_MIX    = 1;
  localparam int CLI_PITCH  = 2;
  localparam int CLI_RECORD = 3;
  localparam int CLI_PLAY   = 4;

  localparam int DEF_NUM_CLIENTS = 5;
  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BUS_W       = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping; zero latency, no state.
module rr_pick #(
  parameter int NUM_CLIENTS = 5,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   vld_o
);

  logic [IDX_W:0] sum;

  // Walk the offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    vld_o   = 1'b0;
    sum     = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_CLIENTS)) sum = sum - (IDX_W + 1)'(NUM_CLIENTS);
      if (req_i[sum[IDX_W-1:0]]) begin
        grant_o                 = '0;
        grant_o[sum[IDX_W-1:0]] = 1'b1;
        idx_o                   = sum[IDX_W-1:0];
        vld_o                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// N-client round-robin arbiter driving one Avalon-MM transaction at a time; grant 1 cycle after req,
// stalls in ISSUE on waitrequest and in WAIT_RD until readdatavalid (bounded when SDRAM_ARB_TIMEOUT_EN).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BUS_W       = DEF_BUS_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        i_req,
  input  logic [NUM_CLIENTS-1:0]        i_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] i_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0]             o_rdata,
  output logic [NUM_CLIENTS-1:0]        o_done,
  output logic [NUM_CLIENTS-1:0]        o_grant,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [ADDR_W-1:0]             sdram_address,
  output logic [BUS_W/8-1:0]            sdram_byteenable_n,
  output logic                          sdram_chipselect,
  output logic [BUS_W-1:0]              sdram_writedata,
  output logic                          sdram_read_n,
  output logic                          sdram_write_n,
  input  logic [BUS_W-1:0]              sdram_readdata,
  input  logic                          sdram_readdatavalid,
  input  logic                          sdram_waitrequest
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int BE_W  = BUS_W / 8;
  localparam logic [BE_W-1:0] BE_N_ACTIVE = ~BE_W'((1 << (DATA_W / 8)) - 1);

  state_e                   state_q;
  logic [IDX_W-1:0]         ptr_q, ptr_d, idx_q;
  logic                     we_q;
  logic [NUM_CLIENTS-1:0]   grant_q, done_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [BUS_W-1:0]         wdata_q;
  logic                     cs_q, rd_n_q, wr_n_q;
  logic [BE_W-1:0]          be_n_q;

  logic [NUM_CLIENTS-1:0]   pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_vld;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  assign o_err = err_q;
`else
  localparam int tmo_cyc_unused = TIMEOUT_CYC;
  assign o_err = 1'b0;
`endif

  generate
    if (BUS_W > DATA_W) begin : g_rd_hi
      logic rdata_hi_unused;
      assign rdata_hi_unused = ^sdram_readdata[BUS_W-1:DATA_W];
    end
  endgenerate

  rr_pick #(.NUM_CLIENTS(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick (
    .req_i  (i_req),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign ptr_d = (idx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      be_n_q  <= '1;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: if (pick_vld) begin
          idx_q   <= pick_idx;
          we_q    <= i_we[pick_idx];
          grant_q <= pick_grant;
          addr_q  <= i_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_q <= BUS_W'(i_wdata[pick_idx*DATA_W +: DATA_W]);
          cs_q    <= 1'b1;
          rd_n_q  <= i_we[pick_idx];
          wr_n_q  <= ~i_we[pick_idx];
          be_n_q  <= BE_N_ACTIVE;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: if (!sdram_waitrequest) begin
          cs_q   <= 1'b0;
          rd_n_q <= 1'b1;
          wr_n_q <= 1'b1;
          be_n_q <= '1;
          if (we_q) begin
            done_q  <= grant_q;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_WAIT_RD;
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        ST_WAIT_RD: if (sdram_readdatavalid) begin
          rdata_q <= sdram_readdata[DATA_W-1:0];
          done_q  <= grant_q;
          state_q <= ST_DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          done_q  <= grant_q;
          state_q <= ST_DONE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
`endif
        ST_DONE: begin
          ptr_q   <= ptr_d;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rdata            = rdata_q;
  assign o_done             = done_q;
  assign o_grant            = grant_q;
  assign o_busy             = (state_q != ST_IDLE);
  assign sdram_address      = addr_q;
  assign sdram_byteenable_n = be_n_q;
  assign sdram_chipselect   = cs_q;
  assign sdram_writedata    = wdata_q;
  assign sdram_read_n       = rd_n_q;
  assign sdram_write_n      = wr_n_q;

endmodule
